// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480 VGA timing constants and sync bundle type
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYN    = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYN    = 2;
   localparam int V_BP     = 33;

   // hsync/vsync here are raw "in sync interval" flags; polarity is applied at the outputs
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic sync_b;
      logic blank_b;
   } vga_sync_t;

   localparam vga_sync_t SYNC_IDLE = '{hsync: 1'b0, vsync: 1'b0, sync_b: 1'b1, blank_b: 1'b0};

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enable-gated shift register aligning sync/blank with a pixel pipeline
module vga_delay_line #(
   parameter int               WIDTH   = 4,
   parameter int               DEPTH   = 0,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             vgaclk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_ctrl;
         assign unused_ctrl = ^{vgaclk, reset, en};
         assign dout = din;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge vgaclk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else if (en) begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters with sync/blank generation
// Sync and blank may be delayed by PIPE_DLY enabled cycles to match a downstream pixel pipeline.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int HACTIVE  = H_ACTIVE,
   parameter int HFP      = H_FP,
   parameter int HSYN     = H_SYN,
   parameter int HBP      = H_BP,
   parameter int VACTIVE  = V_ACTIVE,
   parameter int VFP      = V_FP,
   parameter int VSYN     = V_SYN,
   parameter int VBP      = V_BP,
   parameter int CW       = 10,
   parameter bit HPOL     = 1'b0,
   parameter bit VPOL     = 1'b0,
   parameter int PIPE_DLY = 0
) (
   input  logic          vgaclk,
   input  logic          reset,
   input  logic          en,
   output logic          hsync,
   output logic          vsync,
   output logic          sync_b,
   output logic          blank_b,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start
);

   localparam int HMAX     = HACTIVE + HFP + HSYN + HBP;
   localparam int VMAX     = VACTIVE + VFP + VSYN + VBP;
   localparam int HS_START = HACTIVE + HFP;
   localparam int HS_END   = HACTIVE + HFP + HSYN;
   localparam int VS_START = VACTIVE + VFP;
   localparam int VS_END   = VACTIVE + VFP + VSYN;

   localparam logic [CW-1:0] X_LAST = CW'(HMAX - 1);
   localparam logic [CW-1:0] Y_LAST = CW'(VMAX - 1);

   generate
      if (HMAX > (1 << CW) || VMAX > (1 << CW)) begin : g_bad_cw
         $error("vga_timing_gen: HMAX/VMAX do not fit in CW-bit counters");
      end
      if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
         $error("vga_timing_gen: PIPE_DLY must be 0..7");
      end
   endgenerate

   always_ff @(posedge vgaclk or posedge reset) begin
      if (reset) begin
         x <= '0;
         y <= '0;
      end else if (en) begin
         if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

   vga_sync_t raw;
   vga_sync_t dly;

   always_comb begin
      raw         = SYNC_IDLE;
      raw.hsync   = (int'(x) >= HS_START) && (int'(x) < HS_END);
      raw.vsync   = (int'(y) >= VS_START) && (int'(y) < VS_END);
      raw.sync_b  = !(raw.hsync || raw.vsync);
      raw.blank_b = (int'(x) < HACTIVE) && (int'(y) < VACTIVE);
   end

   vga_delay_line #(
      .WIDTH   ($bits(vga_sync_t)),
      .DEPTH   (PIPE_DLY),
      .RST_VAL (SYNC_IDLE)
   ) u_dly (
      .vgaclk (vgaclk),
      .reset  (reset),
      .en     (en),
      .din    (raw),
      .dout   (dly)
   );

   // Reset gating keeps the combinational (PIPE_DLY = 0) path at idle values while reset is held
   logic hs_act;
   logic vs_act;
   assign hs_act      = dly.hsync & ~reset;
   assign vs_act      = dly.vsync & ~reset;
   assign hsync       = hs_act ? HPOL : ~HPOL;
   assign vsync       = vs_act ? VPOL : ~VPOL;
   assign sync_b      = dly.sync_b | reset;
   assign blank_b     = dly.blank_b & ~reset;
   assign line_start  = en & ~reset & (x == '0);
   assign frame_start = line_start & (y == '0);

endmodule
